// File: rtl/cpu_wb_pkg.sv
// Shared writeback-stage types: load/result-select encodings and the per-lane pipeline register record.
package cpu_wb_pkg;

    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_LB   = 3'd1,
        LD_LBU  = 3'd2,
        LD_LH   = 3'd3,
        LD_LHU  = 3'd4,
        LD_LW   = 3'd5
    } load_t;

    typedef enum logic [1:0] {
        WB_PC8  = 2'd0,
        WB_ALU  = 2'd1,
        WB_OUTB = 2'd2,
        WB_DM   = 2'd3
    } wb_sel_t;

    localparam logic [31:0] PC_LINK_OFFSET = 32'd8;

    typedef struct packed {
        logic    valid;
        logic [31:0] pc;
        load_t   load_type;
        wb_sel_t wb_sel;
        logic    rf_wr;
        logic    except;
        logic    done;
        logic    done_r;
    } wb_lane_t;

    // Reset selects the ALU path so an empty stage presents a zero result rather than pc+8.
    localparam wb_lane_t LANE_RESET = '{
        valid:     1'b0,
        pc:        32'd0,
        load_type: LD_NONE,
        wb_sel:    WB_ALU,
        rf_wr:     1'b0,
        except:    1'b0,
        done:      1'b0,
        done_r:    1'b0
    };

    function automatic logic [31:0] link_addr(input logic [31:0] pc);
        return pc + PC_LINK_OFFSET;
    endfunction

endpackage

// File: rtl/wb_load_ext.sv
// Little-endian load extension for one lane: picks the byte/half addressed by the low address bits.
module wb_load_ext
    import cpu_wb_pkg::*;
#(
    parameter int DW = 32
) (
    input  load_t          load_type_i,
    input  logic [1:0]     addr_lo_i,
    input  logic [DW-1:0]  word_i,
    output logic [DW-1:0]  data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[{addr_lo_i, 3'b000} +: 8];
        half_sel = word_i[{addr_lo_i[1], 4'b0000} +: 16];
        case (load_type_i)
            LD_LB:   data_o = {{(DW-8){byte_sel[7]}}, byte_sel};
            LD_LBU:  data_o = {{(DW-8){1'b0}}, byte_sel};
            LD_LH:   data_o = {{(DW-16){half_sel[15]}}, half_sel};
            LD_LHU:  data_o = {{(DW-16){1'b0}}, half_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/wb_stage_multi.sv
// N-lane MEM/WB register with result select, one-shot ordered regfile write gating and a retire counter.
// Optional trace ports are enabled by defining WB_TRACE_EN.
module wb_stage_multi
    import cpu_wb_pkg::*;
#(
    parameter int LANES = 2,
    parameter int DW    = 32,
    parameter int RW    = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_flush,
    input  logic                  wb_wr,
    input  logic                  wb_dis_wr,
    input  logic [LANES-1:0]      mem_valid,
    input  logic [LANES*32-1:0]   mem_pc,
    input  logic [LANES*DW-1:0]   mem_alu_out,
    input  logic [LANES*DW-1:0]   mem_out_b,
    input  logic [LANES*DW-1:0]   mem_dm_out,
    input  logic [LANES*3-1:0]    mem_load_type,
    input  logic [LANES*2-1:0]    mem_wb_sel,
    input  logic [LANES*RW-1:0]   mem_dst,
    input  logic [LANES-1:0]      mem_rf_wr,
    input  logic [LANES-1:0]      mem_except,
    output logic [LANES-1:0]      wb_valid,
    output logic [LANES*32-1:0]   wb_pc,
    output logic [LANES-1:0]      wb_except,
    output logic [LANES*RW-1:0]   wb_dst,
    output logic [LANES*DW-1:0]   wb_result,
    output logic [LANES-1:0]      wb_rf_we,
    output logic [31:0]           wb_retire_cnt
`ifdef WB_TRACE_EN
    ,
    output logic [LANES*32-1:0]   debug_wb_pc,
    output logic [LANES*4-1:0]    debug_wb_rf_wen,
    output logic [LANES*RW-1:0]   debug_wb_rf_wnum,
    output logic [LANES*DW-1:0]   debug_wb_rf_wdata
`endif
);

    wb_lane_t      lane_q [LANES];
    wb_lane_t      lane_d [LANES];
    logic [DW-1:0] alu_q  [LANES];
    logic [DW-1:0] alu_d  [LANES];
    logic [DW-1:0] outb_q [LANES];
    logic [DW-1:0] outb_d [LANES];
    logic [DW-1:0] dm_q   [LANES];
    logic [DW-1:0] dm_d   [LANES];
    logic [RW-1:0] dst_q  [LANES];
    logic [RW-1:0] dst_d  [LANES];
    logic [31:0]   retire_cnt_q, retire_cnt_d;

    logic [DW-1:0]    ext_data    [LANES];
    logic [DW-1:0]    lane_result [LANES];
    logic [LANES-1:0] base_we, ordered_we, final_we, resolved, retire;
    logic             older_except;
    logic [31:0]      retire_sum;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        wb_load_ext #(.DW(DW)) u_load_ext (
            .load_type_i (lane_q[g].load_type),
            .addr_lo_i   (alu_q[g][1:0]),
            .word_i      (dm_q[g]),
            .data_o      (ext_data[g])
        );
    end

    // An exception in lane i kills writes and retirement of itself and every younger lane.
    always_comb begin
        older_except = 1'b0;
        base_we      = '0;
        ordered_we   = '0;
        retire       = '0;
        for (int i = 0; i < LANES; i++) begin
            base_we[i]    = lane_q[i].valid & lane_q[i].rf_wr & ~lane_q[i].except
                          & (dst_q[i] != '0) & ~lane_q[i].done;
            ordered_we[i] = base_we[i] & ~older_except;
            retire[i]     = lane_q[i].valid & ~lane_q[i].except & ~older_except
                          & ~lane_q[i].done_r & ~wb_dis_wr;
            older_except  = older_except | lane_q[i].except;
        end
        final_we = ordered_we;
        for (int i = 0; i < LANES; i++) begin
            for (int j = i + 1; j < LANES; j++) begin
                if (ordered_we[j] && (dst_q[j] == dst_q[i])) begin
                    final_we[i] = 1'b0;
                end
            end
        end
        final_we = final_we & ~{LANES{wb_dis_wr}};
        // A lane beaten by a younger same-destination write is resolved too, so it never lands later while held.
        resolved = ordered_we & ~{LANES{wb_dis_wr}};
        retire_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            retire_sum = retire_sum + 32'(retire[i]);
        end
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            case (lane_q[i].wb_sel)
                WB_PC8:  lane_result[i] = DW'(link_addr(lane_q[i].pc));
                WB_ALU:  lane_result[i] = alu_q[i];
                WB_OUTB: lane_result[i] = outb_q[i];
                default: lane_result[i] = ext_data[i];
            endcase
        end
    end

    always_comb begin
        lane_d       = lane_q;
        alu_d        = alu_q;
        outb_d       = outb_q;
        dm_d         = dm_q;
        dst_d        = dst_q;
        retire_cnt_d = retire_cnt_q + retire_sum;
        for (int i = 0; i < LANES; i++) begin
            if (wb_flush) begin
                lane_d[i].valid  = 1'b0;
                lane_d[i].rf_wr  = 1'b0;
                lane_d[i].except = 1'b0;
                lane_d[i].done   = 1'b0;
                lane_d[i].done_r = 1'b0;
            end else if (wb_wr) begin
                lane_d[i].valid     = mem_valid[i];
                lane_d[i].pc        = mem_pc[i*32 +: 32];
                lane_d[i].load_type = load_t'(mem_load_type[i*3 +: 3]);
                lane_d[i].wb_sel    = wb_sel_t'(mem_wb_sel[i*2 +: 2]);
                lane_d[i].rf_wr     = mem_rf_wr[i];
                lane_d[i].except    = mem_except[i];
                lane_d[i].done      = 1'b0;
                lane_d[i].done_r    = 1'b0;
                alu_d[i]            = mem_alu_out[i*DW +: DW];
                outb_d[i]           = mem_out_b[i*DW +: DW];
                dm_d[i]             = mem_dm_out[i*DW +: DW];
                dst_d[i]            = mem_dst[i*RW +: RW];
            end else begin
                if (resolved[i]) begin
                    lane_d[i].done = 1'b1;
                end
                if (retire[i]) begin
                    lane_d[i].done_r = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) begin
                lane_q[i] <= LANE_RESET;
                alu_q[i]  <= '0;
                outb_q[i] <= '0;
                dm_q[i]   <= '0;
                dst_q[i]  <= '0;
            end
            retire_cnt_q <= '0;
        end else begin
            lane_q       <= lane_d;
            alu_q        <= alu_d;
            outb_q       <= outb_d;
            dm_q         <= dm_d;
            dst_q        <= dst_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    always_comb begin
        wb_valid  = '0;
        wb_pc     = '0;
        wb_except = '0;
        wb_dst    = '0;
        wb_result = '0;
        for (int i = 0; i < LANES; i++) begin
            wb_valid[i]           = lane_q[i].valid;
            wb_pc[i*32 +: 32]     = lane_q[i].pc;
            wb_except[i]          = lane_q[i].except;
            wb_dst[i*RW +: RW]    = dst_q[i];
            wb_result[i*DW +: DW] = lane_result[i];
        end
        wb_rf_we      = final_we;
        wb_retire_cnt = retire_cnt_q;
    end

`ifdef WB_TRACE_EN
    always_comb begin
        debug_wb_pc       = wb_pc;
        debug_wb_rf_wnum  = wb_dst;
        debug_wb_rf_wdata = wb_result;
        debug_wb_rf_wen   = '0;
        for (int i = 0; i < LANES; i++) begin
            debug_wb_rf_wen[i*4 +: 4] = {4{final_we[i]}};
        end
    end
`endif

endmodule
